// File: rtl/ctrl_seq_pkg.sv
// Shared definitions for the control sequencer: state encoding, result-routing
// codes, instruction field positions and the control-word packing.
package ctrl_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  localparam logic [1:0] REC_ALU  = 2'b00;
  localparam logic [1:0] REC_IR   = 2'b01;
  localparam logic [1:0] REC_MEM  = 2'b10;
  localparam logic [1:0] REC_NONE = 2'b11;

  localparam int MEM_OP_BIT = 15;
  localparam int A_MSB      = 14;
  localparam int A_LSB      = 12;
  localparam int B_MSB      = 11;
  localparam int B_LSB      = 8;
  localparam int STORE_BIT  = 11;
  localparam int C_MSB      = 7;
  localparam int C_LSB      = 5;
  localparam int CIN_BIT    = 4;

  localparam logic [15:0] HALT_OP_DEFAULT  = 16'hFFFF;
  localparam logic [3:0]  WAIT_MAX_DEFAULT = 4'd15;

  typedef struct packed {
    logic [2:0] a;
    logic [3:0] b;
    logic [2:0] c;
    logic       cin;
    logic [1:0] rec;
    logic       pc_en;
    logic       reg_en;
  } ctrl_fields_t;

  localparam ctrl_fields_t CW_IDLE = '{a: 3'd0, b: 4'd0, c: 3'd0, cin: 1'b0,
                                       rec: REC_NONE, pc_en: 1'b0, reg_en: 1'b0};

  function automatic logic [15:0] pack_ctrl_word(input ctrl_fields_t f);
    return {1'b0, f.a, f.b, f.cin, f.c, f.rec, f.pc_en, f.reg_en};
  endfunction

endpackage

// File: rtl/cw_pack_reg.sv
// Registered packing of the per-cycle control fields into the 16-bit control word.
// Fed with next-cycle fields so ctrl_word lines up with the individual field outputs.
module cw_pack_reg
  import ctrl_seq_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  ctrl_fields_t fields,
  output logic [15:0]  ctrl_word
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl_word <= pack_ctrl_word(CW_IDLE);
    end else begin
      ctrl_word <= pack_ctrl_word(fields);
    end
  end

endmodule

// File: rtl/ctrl_sequencer.sv
// Multi-cycle fetch/decode/exec/mem/wb control sequencer with memory wait timeout.
// Optional single-step operation is enabled by defining STEP_MODE_EN.
module ctrl_sequencer
  import ctrl_seq_pkg::*;
#(
  parameter logic [3:0]  WAIT_MAX = WAIT_MAX_DEFAULT,
  parameter logic [15:0] HALT_OP  = HALT_OP_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
`ifdef STEP_MODE_EN
  input  logic        step,
`endif
  input  logic        mem_ready,
  input  logic [15:0] mem_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [2:0]  input_a,
  output logic [3:0]  input_b,
  output logic [2:0]  input_c,
  output logic        cin,
  output logic [1:0]  rec,
  output logic        pc_en,
  output logic        reg_en,
  output logic [15:0] ctrl_word,
  output logic        busy,
  output logic        halted,
  output logic        err
);

  state_t       state_reg, state_next;
  logic [15:0]  ir_reg, ir_next;
  logic [3:0]   wait_cnt_reg, wait_cnt_next;
  logic         err_reg, err_next;
  ctrl_fields_t fields_reg, fields_next;
  logic         mem_req_reg, mem_req_next;
  logic         mem_we_reg, mem_we_next;
  logic         busy_reg, busy_next;
  logic         halted_reg, halted_next;
  logic         waiting;
  logic         timeout;
  logic         store;

`ifdef STEP_MODE_EN
  localparam state_t RETIRE_STATE = S_IDLE;
`else
  localparam state_t RETIRE_STATE = S_FETCH;
`endif

  always_comb begin
    state_next    = state_reg;
    ir_next       = ir_reg;
    wait_cnt_next = wait_cnt_reg;
    timeout       = 1'b0;
    // A FETCH cycle with mem_req low is the back-off cycle after a timeout.
    waiting       = ((state_reg == S_FETCH) || (state_reg == S_MEM)) && mem_req_reg;

    case (state_reg)
      S_IDLE: begin
`ifdef STEP_MODE_EN
        if (step) state_next = S_FETCH;
`else
        state_next = S_FETCH;
`endif
      end
      S_FETCH: begin
        if (waiting && mem_ready) begin
          ir_next    = mem_rdata;
          state_next = S_DECODE;
        end
      end
      S_DECODE: begin
        if (ir_reg == HALT_OP)       state_next = S_HALT;
        else if (ir_reg[MEM_OP_BIT]) state_next = S_MEM;
        else                         state_next = S_EXEC;
      end
      S_EXEC:  state_next = RETIRE_STATE;
      S_MEM:   if (mem_ready) state_next = S_WB;
      S_WB:    state_next = RETIRE_STATE;
      S_HALT:  state_next = S_HALT;
      default: state_next = S_IDLE;
    endcase

    // The cycle that would take the count to WAIT_MAX aborts; ready in that cycle still wins.
    if (waiting && !mem_ready) begin
      if (wait_cnt_reg == WAIT_MAX - 4'd1) begin
        timeout    = 1'b1;
        state_next = S_FETCH;
      end else begin
        wait_cnt_next = wait_cnt_reg + 4'd1;
      end
    end
    if ((state_next != state_reg) || timeout || mem_ready) wait_cnt_next = 4'd0;

    err_next = err_reg | timeout;
  end

  always_comb begin
    fields_next  = CW_IDLE;
    mem_req_next = 1'b0;
    mem_we_next  = 1'b0;
    store        = ir_next[STORE_BIT];
    busy_next    = !((state_next == S_IDLE) || (state_next == S_HALT));
    halted_next  = (state_next == S_HALT);

    case (state_next)
      S_FETCH: begin
        mem_req_next    = !timeout;
        fields_next.rec = REC_IR;
      end
      S_EXEC: begin
        fields_next.a      = ir_next[A_MSB:A_LSB];
        fields_next.b      = ir_next[B_MSB:B_LSB];
        fields_next.c      = ir_next[C_MSB:C_LSB];
        fields_next.cin    = ir_next[CIN_BIT];
        fields_next.rec    = REC_ALU;
        fields_next.reg_en = 1'b1;
        fields_next.pc_en  = 1'b1;
      end
      S_MEM: begin
        mem_req_next    = 1'b1;
        mem_we_next     = store;
        fields_next.rec = store ? REC_NONE : REC_MEM;
      end
      S_WB: begin
        fields_next.c      = ir_next[C_MSB:C_LSB];
        fields_next.rec    = store ? REC_NONE : REC_MEM;
        fields_next.reg_en = !store;
        fields_next.pc_en  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= S_IDLE;
      ir_reg       <= 16'd0;
      wait_cnt_reg <= 4'd0;
      err_reg      <= 1'b0;
      fields_reg   <= CW_IDLE;
      mem_req_reg  <= 1'b0;
      mem_we_reg   <= 1'b0;
      busy_reg     <= 1'b0;
      halted_reg   <= 1'b0;
    end else begin
      state_reg    <= state_next;
      ir_reg       <= ir_next;
      wait_cnt_reg <= wait_cnt_next;
      err_reg      <= err_next;
      fields_reg   <= fields_next;
      mem_req_reg  <= mem_req_next;
      mem_we_reg   <= mem_we_next;
      busy_reg     <= busy_next;
      halted_reg   <= halted_next;
    end
  end

  cw_pack_reg u_cw_pack_reg (
    .clk       (clk),
    .reset     (reset),
    .fields    (fields_next),
    .ctrl_word (ctrl_word)
  );

  assign mem_req = mem_req_reg;
  assign mem_we  = mem_we_reg;
  assign input_a = fields_reg.a;
  assign input_b = fields_reg.b;
  assign input_c = fields_reg.c;
  assign cin     = fields_reg.cin;
  assign rec     = fields_reg.rec;
  assign pc_en   = fields_reg.pc_en;
  assign reg_en  = fields_reg.reg_en;
  assign busy    = busy_reg;
  assign halted  = halted_reg;
  assign err     = err_reg;

endmodule
